// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch sequencer: fetch-control codes, FSM state
// encodings, datapath widths and a saturating-increment helper.
package fetch_pkg;

  localparam int PC_W  = 10;  // fetch-unit address width
  localparam int TMO_W = 8;   // memory-wait timeout counter width

  // Command presented to the fetch unit every cycle.
  typedef enum logic [1:0] {
    FETCH_NORMAL = 2'b00,
    FETCH_JUMP   = 2'b01,
    FETCH_RETURN = 2'b10,
    FETCH_HOLD   = 2'b11
  } fetch_ctrl_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_HALT     = 2'b10
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
    return (v == '1) ? v : v + TMO_W'(1);
  endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry; a pop from an empty stack is ignored. Both are flagged for
// one cycle so the owner can keep a sticky error.
module ret_addr_stack
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] top,
  output logic [3:0]      count,
  output logic            overflow,
  output logic            underflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PC_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [3:0]       count_q;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;
  logic             full;
  logic             empty;

  assign full      = (count_q == 4'(DEPTH));
  assign empty     = (count_q == 4'd0);
  assign ptr_inc   = ptr_q + PTR_W'(1);
  assign ptr_dec   = ptr_q - PTR_W'(1);
  assign overflow  = push && full;
  assign underflow = pop && !push && empty;
  assign top       = empty ? '0 : mem_q[ptr_q];
  assign count     = count_q;

  // Pointer, occupancy and entry storage; the pointer always names the top.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the entries are reset on purpose: the stack is tiny and a
      // cleared RAS must read back as zero rather than stale addresses.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else if (push) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values of ptr_q/count_q, independent of statement order.
      mem_q[ptr_inc] <= din;
      ptr_q          <= ptr_inc;
      if (!full) count_q <= count_q + 4'd1;
    end else if (pop && !empty) begin
      ptr_q   <= ptr_dec;
      count_q <= count_q - 4'd1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: turns decoded instruction flags into a per-cycle fetch
// command, stalls fetch across load/store memory handshakes (with timeout),
// handles halt/resume and owns the return-address stack for call/ret.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int RAS_DEPTH   = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  input  logic            is_halt,
  input  logic            is_ldst,
  input  logic            is_ret,
  input  logic            is_call,
  input  logic            is_jump,
  input  logic            is_branch,
  input  logic            cmp_taken,
  input  logic            mem_ack,
  input  logic            resume,
  input  logic [PC_W-1:0] pc_in,
  output logic [1:0]      fetch_control,
  output logic [PC_W-1:0] ra_addr,
  output logic            mem_req,
  output logic            stall,
  output logic            halted,
  output logic            ras_err,
  output logic            mem_err,
  output logic [3:0]      ras_count
);

  state_e            state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              ras_err_q;
  logic              mem_err_q;
  fetch_ctrl_e       fc;
  logic              req;
  logic              push;
  logic              pop;
  logic              mem_err_set;
  logic              ras_ovf;
  logic              ras_unf;

  ret_addr_stack #(
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .din       (pc_in),
    .top       (ra_addr),
    .count     (ras_count),
    .overflow  (ras_ovf),
    .underflow (ras_unf)
  );

  // Priority decode of the flags and next-state/timeout selection.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves one unassigned and infers a latch.
    fc          = FETCH_NORMAL;
    req         = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    mem_err_set = 1'b0;
    state_d     = state_q;
    tmo_d       = tmo_q;
    case (state_q)
      ST_RUN: begin
        if (instr_valid) begin
          if (is_halt) begin
            fc      = FETCH_HOLD;
            state_d = ST_HALT;
          end else if (is_ldst) begin
            fc  = FETCH_HOLD;
            req = 1'b1;
            if (!mem_ack) begin
              state_d = ST_MEM_WAIT;
              tmo_d   = '0;
            end
          end else if (is_ret) begin
            fc  = FETCH_RETURN;
            pop = 1'b1;
          end else if (is_call) begin
            fc   = FETCH_JUMP;
            push = 1'b1;
          end else if (is_jump) begin
            fc = FETCH_JUMP;
          end else if (is_branch && cmp_taken) begin
            fc = FETCH_JUMP;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          // Request is still up in the ack cycle; fetch resumes immediately.
          req     = 1'b1;
          state_d = ST_RUN;
          tmo_d   = '0;
        end else if (tmo_q >= TMO_W'(MEM_TIMEOUT)) begin
          // Abandon the access: drop the request and release fetch.
          mem_err_set = 1'b1;
          state_d     = ST_RUN;
          tmo_d       = '0;
        end else begin
          fc    = FETCH_HOLD;
          req   = 1'b1;
          tmo_d = sat_inc(tmo_q);
        end
      end
      ST_HALT: begin
        fc = FETCH_HOLD;
        if (resume) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State, timeout counter and sticky error flags; reset wins over all.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      tmo_q     <= '0;
      ras_err_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      ras_err_q <= ras_err_q | ras_ovf | ras_unf;
      mem_err_q <= mem_err_q | mem_err_set;
    end
  end

  assign fetch_control = fc;
  assign mem_req       = req;
  assign stall         = (fc == FETCH_HOLD);
  assign halted        = (state_q == ST_HALT);
  assign ras_err       = ras_err_q;
  assign mem_err       = mem_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by
// random flag traffic, all compared against a behavioural model built from
// a queue of return addresses and simple wait/halt bookkeeping.
module tb_fetch_sequencer;

  localparam int RAS_D = 4;
  localparam int TMO   = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid, is_halt, is_ldst, is_ret, is_call, is_jump;
  logic       is_branch, cmp_taken, mem_ack, resume;
  logic [9:0] pc_in;
  logic [1:0] fetch_control;
  logic [9:0] ra_addr;
  logic       mem_req, stall, halted, ras_err, mem_err;
  logic [3:0] ras_count;

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model state.
  bit         m_halt;
  bit         m_wait;
  int         m_wait_cycles;
  logic [9:0] m_ras[$];
  bit         m_ras_err;
  bit         m_mem_err;

  fetch_sequencer #(
    .RAS_DEPTH  (RAS_D),
    .MEM_TIMEOUT(TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .is_halt      (is_halt),
    .is_ldst      (is_ldst),
    .is_ret       (is_ret),
    .is_call      (is_call),
    .is_jump      (is_jump),
    .is_branch    (is_branch),
    .cmp_taken    (cmp_taken),
    .mem_ack      (mem_ack),
    .resume       (resume),
    .pc_in        (pc_in),
    .fetch_control(fetch_control),
    .ra_addr      (ra_addr),
    .mem_req      (mem_req),
    .stall        (stall),
    .halted       (halted),
    .ras_err      (ras_err),
    .mem_err      (mem_err),
    .ras_count    (ras_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    instr_valid = 0; is_halt = 0; is_ldst = 0; is_ret = 0; is_call = 0;
    is_jump = 0; is_branch = 0; cmp_taken = 0; mem_ack = 0; resume = 0;
    pc_in = '0; reset = 0;
  endtask

  // Expected combinational outputs for the current inputs.
  task automatic model_eval(output logic [1:0] e_fc, output logic e_req);
    e_fc  = 2'd0;
    e_req = 1'b0;
    if (m_halt) begin
      e_fc = 2'd3;
    end else if (m_wait) begin
      if (mem_ack) e_req = 1'b1;
      else if (m_wait_cycles < TMO) begin e_fc = 2'd3; e_req = 1'b1; end
    end else if (instr_valid) begin
      if (is_halt)                    e_fc = 2'd3;
      else if (is_ldst)               begin e_fc = 2'd3; e_req = 1'b1; end
      else if (is_ret)                e_fc = 2'd2;
      else if (is_call || is_jump)    e_fc = 2'd1;
      else if (is_branch && cmp_taken) e_fc = 2'd1;
    end
  endtask

  // Apply the effect of the coming clock edge to the model.
  task automatic model_commit();
    if (reset) begin
      m_halt = 0; m_wait = 0; m_wait_cycles = 0;
      m_ras.delete(); m_ras_err = 0; m_mem_err = 0;
    end else if (m_halt) begin
      if (resume) m_halt = 0;
    end else if (m_wait) begin
      if (mem_ack) begin
        m_wait = 0; m_wait_cycles = 0;
      end else if (m_wait_cycles >= TMO) begin
        m_wait = 0; m_wait_cycles = 0; m_mem_err = 1;
      end else begin
        m_wait_cycles++;
      end
    end else if (instr_valid) begin
      if (is_halt) begin
        m_halt = 1;
      end else if (is_ldst) begin
        if (!mem_ack) begin m_wait = 1; m_wait_cycles = 0; end
      end else if (is_ret) begin
        if (m_ras.size() == 0) m_ras_err = 1;
        else void'(m_ras.pop_back());
      end else if (is_call) begin
        m_ras.push_back(pc_in);
        if (m_ras.size() > RAS_D) begin
          void'(m_ras.pop_front());
          m_ras_err = 1;
        end
      end
    end
  endtask

  // One clock: compare outputs on the falling edge, then advance the model.
  task automatic cycle();
    logic [1:0] e_fc;
    logic       e_req;
    logic [9:0] e_ra;
    model_eval(e_fc, e_req);
    e_ra = (m_ras.size() == 0) ? 10'd0 : m_ras[$];
    @(negedge clk);
    if (!reset) begin
      check("fetch_control", 10'(fetch_control), 10'(e_fc));
      check("stall",         10'(stall),         10'(e_fc == 2'd3));
      check("mem_req",       10'(mem_req),       10'(e_req));
      check("ra_addr",       ra_addr,            e_ra);
      check("ras_count",     10'(ras_count),     10'(m_ras.size()));
      check("halted",        10'(halted),        10'(m_halt));
      check("ras_err",       10'(ras_err),       10'(m_ras_err));
      check("mem_err",       10'(mem_err),       10'(m_mem_err));
    end
    model_commit();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_in();
    m_halt = 0; m_wait = 0; m_wait_cycles = 0; m_ras_err = 0; m_mem_err = 0;

    // Reset, then valid with no flags.
    reset = 1;
    @(posedge clk); #1;
    cycle();
    clear_in();
    for (int i = 0; i < 3; i++) begin instr_valid = 1; cycle(); end

    // Call then return.
    clear_in(); instr_valid = 1; is_call = 1; pc_in = 10'h005; cycle();
    clear_in(); cycle();
    clear_in(); instr_valid = 1; is_ret = 1; pc_in = 10'h0ff; cycle();
    clear_in(); cycle();

    // Load/store acknowledged after three held cycles.
    clear_in(); instr_valid = 1; is_ldst = 1; cycle();
    clear_in(); cycle(); cycle();
    mem_ack = 1; cycle();
    clear_in(); cycle();

    // Load/store never acknowledged: timeout path.
    clear_in(); instr_valid = 1; is_ldst = 1; cycle();
    clear_in();
    for (int i = 0; i < TMO + 3; i++) cycle();

    // Five calls then five returns: overflow then underflow.
    for (int i = 1; i <= 5; i++) begin
      clear_in(); instr_valid = 1; is_call = 1; pc_in = 10'(i); cycle();
    end
    for (int i = 0; i < 5; i++) begin
      clear_in(); instr_valid = 1; is_ret = 1; cycle();
    end
    clear_in(); cycle();

    // Halt beats jump; resume; reset in the middle of a memory wait.
    clear_in(); instr_valid = 1; is_halt = 1; is_jump = 1; cycle();
    clear_in(); instr_valid = 1; is_jump = 1; cycle();
    clear_in(); resume = 1; cycle();
    clear_in(); instr_valid = 1; is_ldst = 1; cycle();
    clear_in(); cycle();
    reset = 1; cycle();
    clear_in(); cycle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      clear_in();
      instr_valid = ($urandom_range(3) != 0);
      is_halt     = ($urandom_range(15) == 0);
      is_ldst     = ($urandom_range(7) == 0);
      is_ret      = ($urandom_range(4) == 0);
      is_call     = ($urandom_range(4) == 0);
      is_jump     = ($urandom_range(5) == 0);
      is_branch   = ($urandom_range(3) == 0);
      cmp_taken   = $urandom_range(1);
      mem_ack     = ($urandom_range(5) == 0);
      resume      = ($urandom_range(3) == 0);
      pc_in       = 10'($urandom);
      reset       = ($urandom_range(99) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
